// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and digit-select helper for the seven-segment scanner.
package seven_seg_pkg;

    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 32;

    // Segment order is {a,b,c,d,e,f,g}, active high.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Callers truncate the result to their own digit count.
    function automatic logic [MAX_DIGITS-1:0] digit_onehot(input int unsigned idx);
        logic [MAX_DIGITS-1:0] oh;
        oh = '0;
        oh[idx[4:0]] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to abcdefg segment decoder.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]       nibble_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (nibble_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multi-digit seven-segment scan controller with frame-synchronous value
// update and optional leading-zero blanking.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_W      = $clog2(SCAN_DIV)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic                    ready,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [SEG_W-1:0]        seg,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_flag_q, pend_flag_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic [SEG_W-1:0]        seg_q, seg_d;
    logic                    frame_done_q, frame_done_d;

    logic                    tick;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic [SEG_W-1:0]        dec_seg;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    blanked;

    assign tick     = en && (div_q == DIV_MAX);
    assign boundary = tick && (idx_q == LAST_IDX);
    assign cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_dec (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

    // lz_mask[k] is set when shadow nibbles k..NUM_DIGITS-1 are all zero.
    always_comb begin
        logic acc;
        acc     = 1'b1;
        lz_mask = '0;
        for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
            acc          = acc && (shadow_q[4*(k-1) +: 4] == 4'h0);
            lz_mask[k-1] = acc;
        end
    end

    assign blanked = blank_lz && (idx_q != '0) && lz_mask[idx_q];

    always_comb begin
        div_d        = div_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_flag_d  = pend_flag_q;
        digit_en_d   = digit_en_q;
        seg_d        = seg_q;
        frame_done_d = 1'b0;

        if (!en) begin
            digit_en_d = '0;
            seg_d      = SEG_BLANK;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        if (tick) begin
            digit_en_d = NUM_DIGITS'(digit_onehot(32'(idx_q)));
            seg_d      = blanked ? SEG_BLANK : dec_seg;
            idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end

        if (boundary) begin
            frame_done_d = 1'b1;
            if (pend_flag_q) begin
                shadow_d    = pending_q;
                pend_flag_d = 1'b0;
            end
        end

        // A load coinciding with a boundary lands in pending for the next frame.
        if (load) begin
            pending_d   = value;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_flag_q  <= 1'b0;
            digit_en_q   <= '0;
            seg_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            digit_en_q   <= digit_en_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ready      = ~pend_flag_q;
    assign digit_en   = digit_en_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (4 digits, 4-cycle slots).
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        ready;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic        frame_done;

    int total;
    int bad;
    int kk;

    seven_seg_scanner #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .ready      (ready),
        .digit_en   (digit_en),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, kk, got, exp);
        end
    endtask

    // kk counts rising edges since reset release; sampling is on the falling edge.
    task automatic step();
        @(negedge clk);
        kk++;
    endtask

    task automatic goto(input int t);
        while (kk < t) step();
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        kk       = 0;
        rst      = 1'b1;
        en       = 1'b1;
        load     = 1'b0;
        value    = '0;
        blank_lz = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'h1);
        check_eq("rst_den",   32'(digit_en), 32'h0);
        check_eq("rst_seg",   32'(seg), 32'h0);
        check_eq("rst_fd",    32'(frame_done), 32'h0);
        rst = 1'b0;
        kk  = 0;

        // Basic scan of an all-zero value
        goto(3);  check_eq("pre_den", 32'(digit_en), 32'h0);
                  check_eq("pre_seg", 32'(seg), 32'h0);
        goto(4);  check_eq("d0_den", 32'(digit_en), 32'h1);
                  check_eq("d0_seg", 32'(seg), 32'h7E);
        goto(7);  check_eq("d0_hold", 32'(digit_en), 32'h1);
        goto(8);  check_eq("d1_den", 32'(digit_en), 32'h2);
        goto(12); check_eq("d2_den", 32'(digit_en), 32'h4);
        goto(15); check_eq("fd_low", 32'(frame_done), 32'h0);
        goto(16); check_eq("d3_den", 32'(digit_en), 32'h8);
                  check_eq("fd_pulse", 32'(frame_done), 32'h1);
        goto(17); check_eq("fd_one", 32'(frame_done), 32'h0);

        // Mid-frame load of 12AF
        load = 1'b1; value = 16'h12AF;
        goto(18); load = 1'b0;
                  check_eq("ld_ready0", 32'(ready), 32'h0);
        goto(20); check_eq("old_seg", 32'(seg), 32'h7E);
        goto(31); check_eq("ld_pend", 32'(ready), 32'h0);
        goto(32); check_eq("ld_ready1", 32'(ready), 32'h1);
                  check_eq("fd2", 32'(frame_done), 32'h1);
        goto(36); check_eq("F_seg", 32'(seg), 32'h47);
                  check_eq("F_den", 32'(digit_en), 32'h1);
        goto(40); check_eq("A_seg", 32'(seg), 32'h77);
        goto(44); check_eq("2_seg", 32'(seg), 32'h6D);
        goto(48); check_eq("1_seg", 32'(seg), 32'h30);
                  check_eq("1_den", 32'(digit_en), 32'h8);

        // Two loads in one frame; latest wins, with leading-zero blanking
        goto(49); load = 1'b1; value = 16'h1111; blank_lz = 1'b1;
        goto(50); load = 1'b0;
        goto(53); load = 1'b1; value = 16'h0042;
        goto(54); load = 1'b0;
        goto(68); check_eq("42_d0", 32'(seg), 32'h6D);
        goto(72); check_eq("42_d1", 32'(seg), 32'h33);
        goto(76); check_eq("42_d2", 32'(seg), 32'h00);
                  check_eq("42_d2en", 32'(digit_en), 32'h4);
        goto(80); check_eq("42_d3", 32'(seg), 32'h00);

        // Value zero with blanking
        goto(81); load = 1'b1; value = 16'h0000;
        goto(82); load = 1'b0;
        goto(100); check_eq("z_d0", 32'(seg), 32'h7E);
        goto(104); check_eq("z_d1", 32'(seg), 32'h00);
        goto(108); check_eq("z_d2", 32'(seg), 32'h00);

        // Load exactly on the boundary tick with nothing pending
        goto(111); load = 1'b1; value = 16'h0005;
        goto(112); load = 1'b0;
                   check_eq("z_d3", 32'(seg), 32'h00);
                   check_eq("bd_ready0", 32'(ready), 32'h0);
        goto(116); check_eq("bd_old", 32'(seg), 32'h7E);
        goto(127); check_eq("bd_pend", 32'(ready), 32'h0);
        goto(128); check_eq("bd_ready1", 32'(ready), 32'h1);
        goto(132); check_eq("5_d0", 32'(seg), 32'h5B);
        goto(136); check_eq("5_d1", 32'(seg), 32'h00);
                   check_eq("5_d1en", 32'(digit_en), 32'h2);

        // en dropped for 10 cycles mid-slot; load handshake still works
        goto(137); en = 1'b0;
        goto(138); check_eq("off_den", 32'(digit_en), 32'h0);
                   check_eq("off_seg", 32'(seg), 32'h0);
        goto(139); load = 1'b1; value = 16'h0077;
        goto(140); load = 1'b0;
        goto(141); check_eq("off_ready", 32'(ready), 32'h0);
        goto(147); en = 1'b1;
        goto(149); check_eq("res_dark", 32'(digit_en), 32'h0);
        goto(150); check_eq("res_d2", 32'(digit_en), 32'h4);
        goto(153); check_eq("res_fd0", 32'(frame_done), 32'h0);
        goto(154); check_eq("res_fd1", 32'(frame_done), 32'h1);
                   check_eq("res_d3", 32'(digit_en), 32'h8);
                   check_eq("res_ready", 32'(ready), 32'h1);
        goto(158); check_eq("77_d0", 32'(seg), 32'h70);
                   check_eq("77_den", 32'(digit_en), 32'h1);

        // Asynchronous reset mid-frame discards a pending value
        goto(159); load = 1'b1; value = 16'h0033;
        goto(160); load = 1'b0;
                   check_eq("pre_ar_ready", 32'(ready), 32'h0);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_den",   32'(digit_en), 32'h0);
        check_eq("ar_seg",   32'(seg), 32'h0);
        check_eq("ar_ready", 32'(ready), 32'h1);
        check_eq("ar_fd",    32'(frame_done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        kk  = 0;
        goto(4);  check_eq("ar_d0", 32'(seg), 32'h7E);
                  check_eq("ar_d0en", 32'(digit_en), 32'h1);
        goto(20); check_eq("ar_discard", 32'(seg), 32'h7E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
